// File: rtl/sigdelay_pkg.sv
// Shared definitions for the signal delay / echo block.
//   mode_e    : output mixing mode selected per accepted sample
//   MIN_DELAY : smallest delay the pipeline can serve without the read
//               address colliding with the in-flight write
package sigdelay_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'b00,
    DELAY   = 2'b01,
    ECHO_FF = 2'b10,
    ECHO_FB = 2'b11
  } mode_e;

  localparam int MIN_DELAY = 2;

endpackage

// File: rtl/ram2ports.sv
// Simple dual-port RAM, one write port and one read port, registered read.
//   clk     : clock
//   we      : write enable, wr_data stored at wr_addr
//   wr_addr : write address
//   wr_data : write data
//   re      : read enable, rd_data updated from rd_addr on the next edge
//   rd_addr : read address
//   rd_data : registered read data (read-before-write on equal addresses)
// Contents are deliberately not reset so the array maps onto block RAM.
module ram2ports #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sigdelay_echo.sv
// Sample delay line with bypass, pure delay, feed-forward echo and feedback
// echo modes. Two-stage pipeline: the sample strobe cycle issues the RAM
// read, the following cycle mixes and writes back, output is registered.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   sample_en  : one input sample per high cycle
//   din        : signed input sample
//   delay      : requested delay in samples (0 and 1 behave as 2)
//   mode       : BYPASS / DELAY / ECHO_FF / ECHO_FB
//   fb_shift   : echo gain as arithmetic right shift of the delayed sample
//   dout       : signed output sample, held between strobes
//   dout_valid : one-cycle strobe qualifying dout, two cycles after sample_en
//   filled     : delay line holds at least the effective delay of samples
module sigdelay_echo
  import sigdelay_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_en,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [ADDR_WIDTH-1:0] delay,
  input  logic        [1:0]            mode,
  input  logic        [2:0]            fb_shift,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         filled
);

  localparam logic [ADDR_WIDTH-1:0] MIN_D = ADDR_WIDTH'(MIN_DELAY);

  // Stage 0 state
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] dly_last_q;

  // Stage 1 (latched with the accepted sample)
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_din_q;
  mode_e                 s1_mode_q;
  logic [2:0]            s1_shift_q;
  logic [ADDR_WIDTH-1:0] s1_ptr_q;
  logic                  s1_fill_q;

  // Output stage
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q;

  logic [ADDR_WIDTH-1:0] eff_delay;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] cnt_base;
  logic                  delay_changed;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;

  logic signed [DATA_WIDTH-1:0] d_val;
  logic signed [DATA_WIDTH-1:0] d_shifted;
  logic        [DATA_WIDTH:0]   sum;
  logic        [DATA_WIDTH-1:0] sat_val;

  // ---------------- address and fill logic ----------------
  assign eff_delay     = (delay < MIN_D) ? MIN_D : delay;
  // Read lands at least two slots behind the write pointer, so it never
  // meets the write still pending from the previous sample.
  assign rd_addr       = wr_ptr_q - eff_delay;
  assign delay_changed = (delay != dly_last_q);
  // A new delay setting invalidates the history: count restarts from zero.
  assign cnt_base      = delay_changed ? '0 : cnt_q;
  assign filled        = !delay_changed && (cnt_q >= eff_delay);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (sample_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      cnt_d    = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    end
  end

  // ---------------- storage ----------------
  ram2ports #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we      (s1_valid_q),
    .wr_addr (s1_ptr_q),
    .wr_data (wr_data),
    .re      (sample_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- mix logic ----------------
  always_comb begin
    d_val     = s1_fill_q ? $signed(rd_data) : '0;
    d_shifted = d_val >>> s1_shift_q;
    sum       = {s1_din_q[DATA_WIDTH-1], s1_din_q} + {d_shifted[DATA_WIDTH-1], d_shifted};
    // Top two bits disagree only on overflow; the top bit gives the direction.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      sat_val = sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      sat_val = sum[DATA_WIDTH-1:0];

    case (s1_mode_q)
      BYPASS:  dout_d = s1_din_q;
      DELAY:   dout_d = d_val;
      default: dout_d = sat_val;
    endcase

    wr_data = (s1_mode_q == ECHO_FB) ? sat_val : s1_din_q;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      dly_last_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_din_q     <= '0;
      s1_mode_q    <= BYPASS;
      s1_shift_q   <= '0;
      s1_ptr_q     <= '0;
      s1_fill_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= sample_en;
      dout_valid_q <= s1_valid_q;
      if (sample_en) begin
        dly_last_q <= delay;
        s1_din_q   <= din;
        s1_mode_q  <= mode_e'(mode);
        s1_shift_q <= fb_shift;
        s1_ptr_q   <= wr_ptr_q;
        s1_fill_q  <= (cnt_base >= eff_delay);
      end
      if (s1_valid_q) dout_q <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sigdelay_echo.sv
module tb_sigdelay_echo;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_en;
  logic signed [7:0] din;
  logic        [8:0] delay;
  logic        [1:0] mode;
  logic        [2:0] fb_shift;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              filled;

  int tests_run = 0;
  int fails     = 0;

  int vin  [600];
  int vexp [600];
  int vfil [600];
  int n;

  always #5 clk = ~clk;

  sigdelay_echo #(.DATA_WIDTH(8), .ADDR_WIDTH(9)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .sample_en  (sample_en),
    .din        (din),
    .delay      (delay),
    .mode       (mode),
    .fb_shift   (fb_shift),
    .dout       (dout),
    .dout_valid (dout_valid),
    .filled     (filled)
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Streams vin[0..n-1] back-to-back; output of sample k appears after the
  // edge that follows the next sample's strobe cycle.
  task automatic run_stream(input string tag);
    for (int k = 0; k <= n; k++) begin
      if (k < n) begin
        sample_en = 1'b1;
        din       = 8'(vin[k]);
      end else begin
        sample_en = 1'b0;
        din       = '0;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        check($sformatf("%s valid@T+1", tag), int'(dout_valid), 0);
      end else begin
        check($sformatf("%s valid[%0d]", tag, k-1), int'(dout_valid), 1);
        check($sformatf("%s dout[%0d]", tag, k-1), int'(dout), vexp[k-1]);
      end
      if (k < n) check($sformatf("%s filled[%0d]", tag, k), int'(filled), vfil[k]);
    end
    @(posedge clk); #1;
    check($sformatf("%s valid idle", tag), int'(dout_valid), 0);
    check($sformatf("%s dout held", tag), int'(dout), vexp[n-1]);
    $display("[TB] stream %s: %0d samples, delay %0d, mode %0d", tag, n, delay, mode);
  endtask

  initial begin
    rst_n = 1'b0; sample_en = 1'b0; din = '0; delay = 9'd2; mode = 2'b00; fb_shift = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset dout", int'(dout), 0);
    check("reset valid", int'(dout_valid), 0);
    check("reset filled", int'(filled), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // BYPASS: single sample 5
    mode = 2'b00; delay = 9'd2;
    n = 1; vin[0] = 5; vexp[0] = 5; vfil[0] = 0;
    run_stream("bypass");

    // DELAY 3, ramp (delay change clears the fill counter)
    mode = 2'b01; delay = 9'd3;
    n = 6;
    vin  = '{default: 0};
    for (int i = 0; i < 6; i++) vin[i] = i + 1;
    vexp[0:5] = '{0, 0, 0, 1, 2, 3};
    vfil[0:5] = '{0, 0, 1, 1, 1, 1};
    run_stream("delay3");

    // ECHO_FF, shift 1, delay 2, impulse
    mode = 2'b10; fb_shift = 3'd1; delay = 9'd2;
    n = 5;
    vin[0:4]  = '{100, 0, 0, 0, 0};
    vexp[0:4] = '{100, 0, 50, 0, 0};
    vfil[0:4] = '{0, 1, 1, 1, 1};
    run_stream("echo_ff");

    // ECHO_FB, shift 1, delay 0 (acts as 2), impulse
    mode = 2'b11; fb_shift = 3'd1; delay = 9'd0;
    n = 9;
    vin[0:8]  = '{100, 0, 0, 0, 0, 0, 0, 0, 0};
    vexp[0:8] = '{100, 0, 50, 0, 25, 0, 12, 0, 6};
    vfil[0:8] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
    run_stream("echo_fb");

    // ECHO_FF saturation, shift 0, delay 2
    mode = 2'b10; fb_shift = 3'd0; delay = 9'd2;
    n = 6;
    vin[0:5]  = '{120, 0, 120, -128, 0, -128};
    vexp[0:5] = '{120, 0, 127, -128, 120, -128};
    vfil[0:5] = '{0, 1, 1, 1, 1, 1};
    run_stream("sat");

    // DELAY 511 across pointer wrap
    mode = 2'b01; fb_shift = 3'd0; delay = 9'd511;
    n = 600;
    for (int i = 0; i < 600; i++) begin
      int v;
      vin[i]  = i % 256;
      v       = (i - 511) % 256;
      if (v > 127) v -= 256;
      vexp[i] = (i < 511) ? 0 : v;
      vfil[i] = (i + 1 >= 511) ? 1 : 0;
    end
    run_stream("wrap511");

    // Reset mid-stream
    mode = 2'b00; delay = 9'd2;
    sample_en = 1'b1; din = 8'sd7;
    @(posedge clk); #1;
    din = 8'sd8;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst dout", int'(dout), 0);
    check("midrst valid", int'(dout_valid), 0);
    check("midrst filled", int'(filled), 0);
    sample_en = 1'b0; din = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst no strobe %0d", i), int'(dout_valid), 0);
      check($sformatf("midrst dout %0d", i), int'(dout), 0);
    end
    $display("[TB] mid-stream reset sequence done");

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
